// File: rtl/timer_dev_pkg.sv
// Register map, control-field layout, mode codes and FSM encodings shared by the
// timer and the system bridge (device ID).
package timer_dev_pkg;

   localparam logic [3:0] TIMER_DEV_ID = 4'h1;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;
   localparam int CTRL_WD   = 4;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   // Field order matches the CTRL bit positions above: [3] IM, [2:1] Mode, [0] En.
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot/auto-reload modes and a maskable IRQ.
// Writes take effect on the WE edge, reads are combinational, no bus backpressure.
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter int CNT_WD = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DIn,
   output logic [31:0] DOut,
   output logic        IRQ
);

   ctrl_t             ctrl;
   logic [CNT_WD-1:0] preset;
   logic [CNT_WD-1:0] count;
   logic [CNT_WD-1:0] count_nxt;
   state_t            state;
   state_t            state_nxt;
   logic              flag;
   logic              flag_nxt;
   logic              im_nxt;
   logic              ctrl_wr;
   logic              preset_wr;
   logic              reload;
   logic              int_set;
   logic              hw_en_clr;

   assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
   assign preset_wr = WE && (Addr == ADDR_PRESET);
   // Mode codes 1x behave as one-shot.
   assign reload    = (ctrl.mode == MODE_RELOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Transitions look only at the registered CTRL, never at a same-edge write.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      int_set   = 1'b0;
      hw_en_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl.en) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            count_nxt = preset;
            state_nxt = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl.en)
               state_nxt = ST_IDLE;
            else if (count == '0)
               state_nxt = ST_INT;
            else
               count_nxt = count - CNT_WD'(1);
         end
         ST_INT: begin
            int_set = 1'b1;
            if (reload) begin
               state_nxt = ST_LOAD;
            end else begin
               hw_en_clr = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A software write to CTRL/PRESET always wins over a flag set in the same cycle.
   always_comb begin
      flag_nxt = flag;
      if (int_set)
         flag_nxt = 1'b1;
      else if (flag && reload)
         flag_nxt = 1'b0;
      if (ctrl_wr || preset_wr)
         flag_nxt = 1'b0;
      im_nxt = ctrl_wr ? DIn[CTRL_IM] : ctrl.im;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl   <= '0;
         preset <= '0;
         flag   <= 1'b0;
         IRQ    <= 1'b0;
      end else begin
         if (ctrl_wr)
            ctrl <= ctrl_t'(DIn[CTRL_WD-1:0]);
         else if (hw_en_clr)
            ctrl.en <= 1'b0;
         if (preset_wr)
            preset <= DIn[CNT_WD-1:0];
         flag <= flag_nxt;
         IRQ  <= flag_nxt & im_nxt;
      end
   end

   always_comb begin
      DOut = '0;
      case (Addr)
         ADDR_CTRL:   DOut[CTRL_WD-1:0] = ctrl;
         ADDR_PRESET: DOut[CNT_WD-1:0]  = preset;
         ADDR_COUNT:  DOut[CNT_WD-1:0]  = count;
         default:     DOut = '0;
      endcase
   end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer: the device-side responder on the processor bus that the multi-cycle CPU drives with PrAddr/PrDOut/Wen and reads through PrDIn. It sits behind the system bridge, which decodes the device ID and presents a word offset plus write strobe. It returns read data combinationally and drives one bit of the CPU's HWInt vector. It supports one-shot and auto-reload modes with a maskable interrupt.

## Interface
- CNT_WD, 32, width of PRESET/COUNT (DOut zero-extends when < 32)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- Addr  input  2  word offset within device (bridge passes PrAddr[3:2]); 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
- WE  input  1  write strobe for this device (bridge: Wen AND device selected)
- DIn  input  32  write data (PrDOut)
- DOut  output  32  read data for Addr, combinational from registers; reset value 0
- IRQ  output  1  interrupt to one HWInt bit, registered; reset value 0

## Operation
- CTRL bits: [0] En, [2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled); [31:4] read 0, writes ignored.
- PRESET: read/write. COUNT: read-only, writes ignored. Addr 3: reads 0, writes ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq flag 0.
- FSM states: IDLE, LOAD, CNT, INT. Transitions use the registered CTRL value, i.e. the value before any write on the same edge.
  - IDLE: En=1 -> LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: En=0 -> IDLE with COUNT held. COUNT==0 -> INT. Otherwise COUNT <= COUNT-1.
  - INT, Mode 00: En <= 0, flag <= 1 -> IDLE.
  - INT, Mode 01: flag <= 1 -> LOAD.
- IRQ = flag & IM, registered.
- Mode 00: flag stays 1 until any write to CTRL or PRESET clears it.
- Mode 01: flag clears automatically one cycle after being set.
- PRESET written during CNT is used at the next LOAD; the current count is unaffected.
- CTRL write with En=1 while already counting does not restart the count.
- Simultaneous CTRL write and hardware En clear in INT: the software write wins. The flag is still set by INT, and the write clears it on that same edge, so IRQ does not rise.
- PRESET=0: LOAD, then CNT sees 0 and goes straight to INT.
- Async reset mid-operation returns every register to its reset value immediately; no pending IRQ survives.

## Timing
- Write latency: register updates on the edge where WE=1; DOut reflects the new value in the following cycle.
- Edge numbering: the edge that writes En=1 is e0.
  - e1: IDLE->LOAD.
  - e2: COUNT=N.
  - COUNT reaches 0 at e(N+2).
  - e(N+3): enter INT.
  - e(N+4): flag/IRQ set.
  - IRQ first high in the cycle after e(N+4).
- Auto-reload period: LOAD + (N+1) CNT + INT = N+3 cycles between IRQ pulses; each pulse is 1 cycle wide.
- Clear latency: a CTRL/PRESET write at edge ek drops IRQ after ek.

## Structure
- Shared macro header (alongside the CPU's macro definitions) holds:
  - register word offsets
  - CTRL bit positions
  - mode codes
  - FSM state encodings
  - the timer's device ID for the bridge
- Single module, no sub-modules: one FSM block, one register-write block, one combinational read mux.

## Test plan
- Reset: assert rst mid-cycle -> DOut=0 for Addr 0..2 and IRQ=0 immediately; state IDLE.
- One-shot: PRESET=5, CTRL=0x9 at e0 -> COUNT reads 5 after e2 and 0 after e7. IRQ rises after e9. CTRL then reads 0x8. IRQ holds until a CTRL=0 write, then falls the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB at e0 -> 1-cycle IRQ pulses after e7, e13, e19 (period 6). CTRL stays 0xB.
- Masked/boundary: PRESET=0, CTRL=0x1 -> INT at e3, En cleared at e4, IRQ never rises. Writing CTRL=0x8 afterwards keeps IRQ 0 because the flag was cleared.
- Disable mid-count: PRESET=100, CTRL=0x9. Write CTRL=0x8 on the edge after COUNT reads 90 -> COUNT freezes at 89 and no IRQ. Rewriting CTRL=0x9 reloads to 100 two edges later.
- PRESET write during count: PRESET=10 in auto-reload mode, write PRESET=4 mid-count -> current period completes from 10, next period reloads 4, IRQ spacing changes from 13 to 7 cycles.
